// File: rtl/selfmade_video_pkg.sv
// Shared types and helpers for the test-pattern raster source.
package selfmade_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } state_e;

  localparam int unsigned FRAME_W = 8;
  localparam int unsigned PAT_W   = 32;

  typedef struct packed {
    logic [PAT_W-1:0] r;
    logic [PAT_W-1:0] g;
    logic [PAT_W-1:0] b;
  } pixel_t;

  // Channels are reduced modulo 2^depth; callers truncate to their channel width.
  function automatic pixel_t pattern_pixel(input logic [PAT_W-1:0] h,
                                           input logic [PAT_W-1:0] v,
                                           input logic [PAT_W-1:0] frame,
                                           input int unsigned      depth);
    logic [PAT_W-1:0] mask;
    pixel_t           p;
    mask = (depth >= PAT_W) ? '1 : ((PAT_W'(1) << depth) - PAT_W'(1));
    p.r  = h & mask;
    p.g  = v & mask;
    p.b  = (h + v + frame) & mask;
    return p;
  endfunction

endpackage

// File: rtl/selfmade_blank_counter.sv
// Loadable down-counter with terminal-count flag, shared by H and V blanking.
module selfmade_blank_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/selfmade_pixel_source.sv
// Raster test-pattern generator: emits N frames of h/v counts plus RGB pattern
// with horizontal and vertical blanking, then pulses done.
module selfmade_pixel_source
  import selfmade_video_pkg::*;
#(
  parameter int unsigned P_IMGDEPTH = 8,
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned H_BLANK    = 16,
  parameter int unsigned V_BLANK    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [7:0]                    num_frames,
  output logic                          busy,
  output logic                          done,
  output logic                          pixel_valid,
  output logic [$clog2(WIDTH+1)-1:0]    h_count_out,
  output logic [$clog2(HEIGHT+1)-1:0]   v_count_out,
  output logic [7:0]                    frame_idx,
  output logic [P_IMGDEPTH-1:0]         r_out,
  output logic [P_IMGDEPTH-1:0]         g_out,
  output logic [P_IMGDEPTH-1:0]         b_out
);

  localparam int unsigned HW   = $clog2(WIDTH + 1);
  localparam int unsigned VW   = $clog2(HEIGHT + 1);
  localparam int unsigned MAXB = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BW   = $clog2(MAXB + 1);

  localparam logic [HW-1:0] H_IDLE = HW'(WIDTH);
  localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);
  localparam logic [VW-1:0] V_IDLE = VW'(HEIGHT);
  localparam logic [VW-1:0] V_LAST = VW'(HEIGHT - 1);

  state_e               state_q, state_d;
  logic [HW-1:0]        h_q, h_d;
  logic [VW-1:0]        v_q, v_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   nf_q, nf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [P_IMGDEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic                 cnt_load;
  logic [BW-1:0]        cnt_val;
  logic                 cnt_en;
  logic                 cnt_tc;
  pixel_t               pix;

  selfmade_blank_counter #(
    .CNT_W (BW)
  ) u_blank_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    frame_d  = frame_q;
    nf_d     = nf_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (num_frames != '0)) begin
          state_d = ST_ACTIVE;
          h_d     = '0;
          v_d     = '0;
          frame_d = '0;
          nf_d    = num_frames;
        end
      end
      ST_ACTIVE: begin
        if (h_q == H_LAST) begin
          state_d  = ST_HBLANK;
          h_d      = H_IDLE;
          cnt_load = 1'b1;
          cnt_val  = BW'(H_BLANK - 1);
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      ST_HBLANK: begin
        if (!cnt_tc) begin
          cnt_en = 1'b1;
        end else if (v_q == V_LAST) begin
          state_d  = ST_VBLANK;
          v_d      = V_IDLE;
          cnt_load = 1'b1;
          cnt_val  = BW'(V_BLANK - 1);
        end else begin
          state_d = ST_ACTIVE;
          v_d     = v_q + VW'(1);
          h_d     = '0;
        end
      end
      ST_VBLANK: begin
        if (!cnt_tc) begin
          cnt_en = 1'b1;
        end else if ((frame_q + FRAME_W'(1)) == nf_q) begin
          state_d = ST_IDLE;
          frame_d = '0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ACTIVE;
          frame_d = frame_q + FRAME_W'(1);
          h_d     = '0;
          v_d     = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = H_IDLE;
        v_d     = V_IDLE;
        frame_d = '0;
      end
    endcase

    // Abort overrides every transition above, including a final-frame done.
    if (abort) begin
      state_d = ST_IDLE;
      h_d     = H_IDLE;
      v_d     = V_IDLE;
      frame_d = '0;
      done_d  = 1'b0;
    end

    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_ACTIVE);
    pix     = pattern_pixel(PAT_W'(h_d), PAT_W'(v_d), PAT_W'(frame_d), P_IMGDEPTH);
    r_d     = valid_d ? P_IMGDEPTH'(pix.r) : '0;
    g_d     = valid_d ? P_IMGDEPTH'(pix.g) : '0;
    b_d     = valid_d ? P_IMGDEPTH'(pix.b) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= H_IDLE;
      v_q     <= V_IDLE;
      frame_q <= '0;
      nf_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      nf_q    <= nf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pixel_valid = valid_q;
  assign h_count_out = h_q;
  assign v_count_out = v_q;
  assign frame_idx   = frame_q;
  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;

endmodule

// File: tb/tb_selfmade_pixel_source.sv
// Scoreboard bench for selfmade_pixel_source with a small 4x3 raster.
module tb_selfmade_pixel_source;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int HB  = 2;
  localparam int VB  = 3;
  localparam int LN  = W + HB;
  localparam int PER = H * LN + VB;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] num_frames;
  logic       busy, done, pixel_valid;
  logic [2:0] h_count_out;
  logic [1:0] v_count_out;
  logic [7:0] frame_idx, r_out, g_out, b_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  typedef struct packed {
    logic [7:0] h, v, f, r, g, b;
  } pix_rec_t;
  pix_rec_t sb[$];

  selfmade_pixel_source #(
    .P_IMGDEPTH (8),
    .WIDTH      (W),
    .HEIGHT     (H),
    .H_BLANK    (HB),
    .V_BLANK    (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_frames  (num_frames),
    .busy        (busy),
    .done        (done),
    .pixel_valid (pixel_valid),
    .h_count_out (h_count_out),
    .v_count_out (v_count_out),
    .frame_idx   (frame_idx),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected pixel per valid output, checks blank rgb otherwise.
  always @(negedge clk) begin
    pix_rec_t exp_p, act_p;
    if (mon_en) begin
      if (pixel_valid) begin
        act_p = {5'b0, h_count_out, 6'b0, v_count_out, frame_idx, r_out, g_out, b_out};
        if (sb.size() == 0) begin
          chk("pixel_unexpected", 32'(act_p[47:24]), 32'hFFFFFFFF);
        end else begin
          exp_p = sb.pop_front();
          n_checks++;
          if (act_p !== exp_p) begin
            n_fail++;
            $display("FAIL pixel: got %h expected %h (t=%0t)", act_p, exp_p, $time);
          end
        end
        if (h_count_out == 3'd2 && v_count_out == 2'd1 && frame_idx == 8'd0)
          chk("spot_rgb_h2v1f0", 32'({r_out, g_out, b_out}), 32'h020103);
        if (h_count_out == 3'd3 && v_count_out == 2'd2 && frame_idx == 8'd2)
          chk("spot_b_h3v2f2", 32'(b_out), 32'd7);
      end else begin
        chk("blank_rgb", 32'({r_out, g_out, b_out}), 32'd0);
      end
    end
  end

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int v = 0; v < H; v++)
        for (int h = 0; h < W; h++)
          sb.push_back({8'(h), 8'(v), 8'(f), 8'(h), 8'(v), 8'((h + v + f) % 256)});
  endtask

  function automatic logic [15:0] idle_vec(input logic d);
    return {1'b0, d, 1'b0, 3'(W), 2'(H), 8'd0};
  endfunction

  // Runs one start request; per-cycle check of {busy,done,valid,h,v,frame}.
  task automatic run(input int n_exp, input logic [7:0] nf, input int restart_at,
                     input int abort_at, input int rst_at);
    int stop_at, total, c, f, line, pos;
    logic [15:0] exp_v, act_v;
    push_frames(n_exp);
    stop_at = (abort_at > 0) ? abort_at : rst_at;
    total   = (stop_at > 0) ? stop_at + 3 : n_exp * PER + 3;
    @(negedge clk);
    num_frames = nf;
    start      = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      if (stop_at > 0 && i > stop_at) begin
        exp_v = idle_vec(1'b0);
      end else if (i <= n_exp * PER) begin
        c = (i - 1) % PER;
        f = (i - 1) / PER;
        if (c < H * LN) begin
          line  = c / LN;
          pos   = c % LN;
          exp_v = (pos < W) ? {1'b1, 1'b0, 1'b1, 3'(pos), 2'(line), 8'(f)}
                            : {1'b1, 1'b0, 1'b0, 3'(W), 2'(line), 8'(f)};
        end else begin
          exp_v = {1'b1, 1'b0, 1'b0, 3'(W), 2'(H), 8'(f)};
        end
      end else begin
        exp_v = idle_vec(i == n_exp * PER + 1);
      end
      act_v = {busy, done, pixel_valid, h_count_out, v_count_out, frame_idx};
      chk("cycle_state", 32'(act_v), 32'(exp_v));
      if (stop_at > 0 && i == stop_at + 1) sb.delete();
      start = (i == restart_at);
      if (i == restart_at) num_frames = 8'd3;
      abort = (i == abort_at);
      rst   = (i == rst_at);
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    num_frames = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", 32'({busy, done, pixel_valid, h_count_out, v_count_out, frame_idx}),
        32'(idle_vec(1'b0)));
    chk("reset_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    mon_en = 1'b1;

    run(1, 8'd1, 0, 0, 0);
    run(3, 8'd3, 0, 0, 0);

    // start with num_frames = 0 is ignored
    @(negedge clk);
    num_frames = 8'd0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_frames_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_frames_busy2", 32'(busy), 32'd0);

    // start together with abort in IDLE is not accepted
    @(negedge clk);
    num_frames = 8'd1;
    start      = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);

    run(1, 8'd1, 5, 0, 0);
    run(2, 8'd2, 0, 10, 0);
    run(1, 8'd1, 0, 0, 0);
    run(2, 8'd2, 0, 0, 3);
    chk("post_reset_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    run(1, 8'd1, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
